alu_md_unit: RTL and testbench

ALU_MD_UNIT -- requirements
Module: alu_md_unit

---
 rtl/alu_md_unit_pkg.sv | 52 +++++
 rtl/alu_md_unit_md_iter.sv | 139 +++++++++++++
 rtl/alu_md_unit.sv | 140 ++++++++++++++
 tb/tb_alu_md_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_unit_pkg.sv
// Shared constants for the ALU / multiply-divide execution unit.
//   ALU_OP_W  : width of the internal opcode field
//   ZERO_TAG  : ROB tag value meaning "no result"
//   alu_op_e  : internal opcodes (NOP, simple ALU ops, iterative MUL/DIV ops)
//   state_e   : issue/result FSM states of alu_md_unit
//   is_md_op / is_div_op : opcode class helpers
package alu_md_unit_pkg;

  localparam int ALU_OP_W = 6;
  localparam int ZERO_TAG = 0;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_NOP    = 6'd0,
    OP_ADD    = 6'd1,
    OP_SUB    = 6'd2,
    OP_AND    = 6'd3,
    OP_OR     = 6'd4,
    OP_XOR    = 6'd5,
    OP_SLL    = 6'd6,
    OP_SRL    = 6'd7,
    OP_SRA    = 6'd8,
    OP_SLT    = 6'd9,
    OP_SLTU   = 6'd10,
    OP_LUI    = 6'd11,
    OP_AUIPC  = 6'd12,
    OP_JAL    = 6'd13,
    OP_JALR   = 6'd14,
    OP_MUL    = 6'd15,
    OP_MULH   = 6'd16,
    OP_MULHSU = 6'd17,
    OP_MULHU  = 6'd18,
    OP_DIV    = 6'd19,
    OP_DIVU   = 6'd20,
    OP_REM    = 6'd21,
    OP_REMU   = 6'd22
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_md_op(input logic [ALU_OP_W-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_md_unit_md_iter.sv
// Iterative multiply / divide datapath: one bit per enabled cycle, XLEN
// iterations per operation. Signed variants run on operand magnitudes and
// apply the sign afterwards.
//   clk, rst (async, active-low) : clock / reset
//   en     : global run enable, low freezes everything
//   clear  : abandon the current operation (sampled when en)
//   start  : load op/a/b and begin iterating (sampled when en)
//   op     : MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   a, b   : operands (a = multiplicand/dividend, b = multiplier/divisor)
//   busy   : iterating
//   done   : final iteration happens on this cycle's edge (when en)
//   result : final value, stable from the cycle after done until next start
module md_iter
  import alu_md_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     result
);

  localparam int CNT_W = $clog2(XLEN);

  // hi:lo is the product for multiplies; hi = partial remainder and
  // lo = dividend shifting out / quotient shifting in for divides.
  logic [XLEN-1:0]  hi, lo, opb;
  logic [CNT_W-1:0] cnt;
  logic             is_div, is_rem, res_hi, neg_q, neg_r, div0;

  logic             sa, sb, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    sum, shifted;
  logic [XLEN-1:0]  diff, hi_nx, lo_nx;
  logic             ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]  quo, rem;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
    return n ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] x, input logic n);
    return n ? (~x + (2*XLEN)'(1)) : x;
  endfunction

  // Operand decode at start
  always_comb begin
    sa    = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    sb    = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    a_neg = sa & a[XLEN-1];
    b_neg = sb & b[XLEN-1];
    a_mag = neg_if(a, a_neg);
    b_mag = neg_if(b, b_neg);
  end

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, (lo[0] ? opb : '0)};
    shifted = {hi, lo[XLEN-1]};
    ge      = shifted >= {1'b0, opb};
    diff    = shifted[XLEN-1:0] - opb;
    if (is_div) begin
      hi_nx = ge ? diff : shifted[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], ge};
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo[XLEN-1:1]};
    end
  end

  assign done = busy & (cnt == CNT_W'(XLEN-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      is_rem <= 1'b0;
      res_hi <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (en) begin
      if (clear) begin
        busy   <= 1'b0;
        cnt    <= '0;
        hi     <= '0;
        lo     <= '0;
        opb    <= '0;
        is_div <= 1'b0;
        is_rem <= 1'b0;
        res_hi <= 1'b0;
        neg_q  <= 1'b0;
        neg_r  <= 1'b0;
        div0   <= 1'b0;
      end else if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        hi     <= '0;
        lo     <= a_mag;
        opb    <= b_mag;
        is_div <= is_div_op(op);
        is_rem <= (op == OP_REM) | (op == OP_REMU);
        res_hi <= (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_MULHU);
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        div0   <= (b == '0);
      end else if (busy) begin
        hi  <= hi_nx;
        lo  <= lo_nx;
        cnt <= cnt + CNT_W'(1);
        if (done) busy <= 1'b0;
      end
    end
  end

  // Sign fix-up; divide by zero forces an all-ones quotient regardless of
  // operand signs, and the remainder naturally equals the dividend.
  always_comb begin
    prod = neg_if_wide({hi, lo}, neg_q);
    quo  = div0 ? '1 : neg_if(lo, neg_q);
    rem  = neg_if(hi, neg_r);
    if (is_div) result = is_rem ? rem : quo;
    else        result = res_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

endmodule

// File: rtl/alu_md_unit.sv
// Integer execution unit: single-cycle simple ALU ops plus an iterative
// multiply/divide engine, with a one-entry result buffer toward the CDB.
//   clk, rst (async, active-low), rdy (global freeze), clear (ROB flush)
//   in_valid/in_ready/in_op/in_value1/in_value2/in_imm/in_pc/in_src2_imm/
//   in_rob_tag : issue interface from the reservation station
//   out_valid/out_ready/out_rob_tag/out_value : result interface to the CDB
//   (tag and value read as zero whenever out_valid is low)
module alu_md_unit
  import alu_md_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_value1,
  input  logic [XLEN-1:0]  in_value2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_src2_imm,
  input  logic [TAG_W-1:0] in_rob_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_rob_tag,
  output logic [XLEN-1:0]  out_value
);

  localparam int SH_W = $clog2(XLEN);

  state_e              state, state_nx;
  logic [ALU_OP_W-1:0] op;
  logic [XLEN-1:0]     opb, alu_res, md_result;
  logic [SH_W-1:0]     shamt;
  logic                consume, accept, is_md, load_simple, start_md;
  logic                md_busy, md_done;

  logic [XLEN-1:0]     value_p1;
  logic [TAG_W-1:0]    tag_p1;
  logic                sel_md_p1, vld_p1;

  assign op    = ALU_OP_W'(in_op);
  assign opb   = in_src2_imm ? in_imm : in_value2;
  assign shamt = opb[SH_W-1:0];

  // Stage p0: simple-op datapath
  always_comb begin
    case (op)
      OP_ADD:   alu_res = in_value1 + opb;
      OP_SUB:   alu_res = in_value1 - opb;
      OP_AND:   alu_res = in_value1 & opb;
      OP_OR:    alu_res = in_value1 | opb;
      OP_XOR:   alu_res = in_value1 ^ opb;
      OP_SLL:   alu_res = in_value1 << shamt;
      OP_SRL:   alu_res = in_value1 >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(in_value1) >>> shamt);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(in_value1) < $signed(opb))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (in_value1 < opb)};
      OP_LUI:   alu_res = in_imm;
      OP_AUIPC: alu_res = in_pc + in_imm;
      OP_JAL,
      OP_JALR:  alu_res = in_pc + XLEN'(4);
      default:  alu_res = '0;
    endcase
  end

  // Handshake and next-state
  always_comb begin
    state_nx    = state;
    consume     = (state == ST_DONE) & out_ready;
    in_ready    = rdy & ~clear & ((state == ST_IDLE) | consume);
    accept      = in_ready & in_valid & (op != OP_NOP);
    is_md       = is_md_op(op);
    load_simple = accept & ~is_md;
    start_md    = accept & is_md;
    if (clear) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_md) state_nx = ST_BUSY;
            else       state_nx = ST_DONE;
          end else if (state == ST_DONE && out_ready) begin
            state_nx = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (md_done)       state_nx = ST_DONE;
          else if (!md_busy) state_nx = ST_IDLE;  // engine lost its op: recover
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  md_iter #(
    .XLEN (XLEN)
  ) u_md_iter (
    .clk    (clk),
    .rst    (rst),
    .en     (rdy),
    .clear  (rdy & clear),
    .start  (start_md),
    .op     (op),
    .a      (in_value1),
    .b      (opb),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Stage p1: result buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tag_p1    <= TAG_W'(ZERO_TAG);
      value_p1  <= '0;
      sel_md_p1 <= 1'b0;
    end else if (rdy) begin
      state <= state_nx;
      if (accept) begin
        tag_p1    <= in_rob_tag;
        sel_md_p1 <= is_md;
      end
      if (load_simple) value_p1 <= alu_res;
    end
  end

  assign vld_p1      = (state == ST_DONE);
  assign out_valid   = vld_p1;
  assign out_rob_tag = vld_p1 ? tag_p1 : TAG_W'(ZERO_TAG);
  assign out_value   = vld_p1 ? (sel_md_p1 ? md_result : value_p1) : '0;

endmodule

// File: tb/tb_alu_md_unit.sv
// Scoreboard bench for alu_md_unit: directed scenarios plus randomized
// issue traffic, checked against an arithmetic reference model.
module tb_alu_md_unit;
  import alu_md_unit_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, rdy, clear;
  logic             in_valid, in_ready, in_src2_imm;
  logic [5:0]       in_op;
  logic [XLEN-1:0]  in_value1, in_value2, in_imm, in_pc;
  logic [TAG_W-1:0] in_rob_tag;
  logic             out_valid, out_ready;
  logic [TAG_W-1:0] out_rob_tag;
  logic [XLEN-1:0]  out_value;

  alu_md_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_value1   (in_value1),
    .in_value2   (in_value2),
    .in_imm      (in_imm),
    .in_pc       (in_pc),
    .in_src2_imm (in_src2_imm),
    .in_rob_tag  (in_rob_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rob_tag (out_rob_tag),
    .out_value   (out_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int   last_acc = 0;

  // Reference model: results straight from the arithmetic definitions
  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm,
                                             input logic [31:0] pc);
    logic signed [63:0] sa, sbx, ub, p;
    logic [63:0]        pu;
    logic signed [31:0] a32, b32;
    logic [31:0]        r;
    sa  = {{32{a[31]}}, a};
    sbx = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    a32 = a;
    b32 = b;
    r   = 32'h0;
    case (op)
      OP_ADD:    r = a + b;
      OP_SUB:    r = a - b;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_SLL:    r = a << b[4:0];
      OP_SRL:    r = a >> b[4:0];
      OP_SRA:    r = a32 >>> b[4:0];
      OP_SLT:    r = (a32 < b32) ? 32'd1 : 32'd0;
      OP_SLTU:   r = (a < b) ? 32'd1 : 32'd0;
      OP_LUI:    r = imm;
      OP_AUIPC:  r = pc + imm;
      OP_JAL,
      OP_JALR:   r = pc + 32'd4;
      OP_MUL:    begin p = sa * sbx; r = p[31:0]; end
      OP_MULH:   begin p = sa * sbx; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub;  r = p[63:32]; end
      OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      OP_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = a32 / b32;
      end
      OP_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = a32 % b32;
      end
      OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   r = (b == 0) ? a : a % b;
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 64);
      default: return $urandom;
    endcase
  endfunction

  // Drives one issue until accepted and records the expected result
  task automatic issue(input int op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic s2i,
                       input logic [TAG_W-1:0] tag, input int extra);
    logic [31:0] b;
    int          lat, guard;
    bit          acc;
    in_valid    = 1'b1;
    in_op       = op[5:0];
    in_value1   = v1;
    in_value2   = v2;
    in_imm      = imm;
    in_pc       = pc;
    in_src2_imm = s2i;
    in_rob_tag  = tag;
    b     = s2i ? imm : v2;
    lat   = (op >= OP_MUL) ? XLEN + 1 : 1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 300) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else guard++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: op %0d tag %0d never accepted, required within 300 cycles", op, tag);
    end else begin
      sb.push_back('{tag, ref_result(op, v1, b, imm, pc), cyc + lat + extra});
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = OP_NOP;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic monitor();
    bit   seen;
    int   first;
    exp_t e;
    seen  = 1'b0;
    first = 0;
    forever begin
      @(negedge clk);
      if (out_valid !== 1'b1) begin
        seen = 1'b0;
        chk("idle_tag", 32'(out_rob_tag), 32'h0);
        chk("idle_value", out_value, 32'h0);
      end else begin
        if (!seen) begin
          seen  = 1'b1;
          first = cyc;
        end
        if (rdy && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: tag %0d value %h, required no output", out_rob_tag, out_value);
          end else begin
            e = sb.pop_front();
            chk("result_tag", 32'(out_rob_tag), 32'(e.tag));
            chk("result_value", out_value, e.val);
            chk("result_latency", 32'(first), 32'(e.due));
          end
          seen = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int n, prev, op, gap;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_op = OP_NOP; in_value1 = '0; in_value2 = '0;
    in_imm = '0; in_pc = '0; in_src2_imm = 1'b0; in_rob_tag = '0;

    fork
      ready_drv();
      monitor();
      begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_tag", 32'(out_rob_tag), 32'h0);
    chk("rst_value", out_value, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // ADD 5+7, then one idle cycle
    issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 4'd3, 0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_tag", 32'(out_rob_tag), 32'd3);
    chk("add_value", out_value, 32'd12);
    @(negedge clk);
    chk("add_after_valid", 32'(out_valid), 32'h0);
    chk("add_after_tag", 32'(out_rob_tag), 32'h0);
    chk("add_after_value", out_value, 32'h0);
    @(posedge clk); #1;

    // DIVU busy window
    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 4'd2, 0);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    chk("divu_busy_cycles", 32'(n), 32'd32);
    drain();
    issue(OP_REMU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 4'd2, 0);
    issue(OP_DIV, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 4'd1, 0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 4'd4, 0);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 4'd5, 0);
    issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 4'd6, 0);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 4'd7, 0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 1'b0, 4'd8, 0);
    drain();

    // Result held while CDB not granted, then back-to-back
    ready_mode = 0;
    @(posedge clk); #2;
    issue(OP_ADD, 32'h10, 32'h20, 32'd0, 32'd0, 1'b0, 4'd4, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_tag", 32'(out_rob_tag), 32'd4);
      chk("hold_value", out_value, 32'h30);
      chk("hold_in_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1;
    ready_mode = 1;
    issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'd0, 1'b0, 4'd8, 0);
    prev = last_acc;
    for (int i = 0; i < 4; i++) begin
      issue(OP_ADD, 32'(i), 32'h100, 32'h7, 32'd0, 1'(i & 1), 4'(9 + i), 0);
      chk("b2b_accept_gap", 32'(last_acc - prev), 32'd1);
      prev = last_acc;
    end
    drain();

    // Flush in the middle of a multiply, with a competing issue
    issue(OP_MUL, 32'd123, 32'd456, 32'd0, 32'd0, 1'b0, 4'd5, 0);
    repeat (9) @(posedge clk);
    #1;
    clear = 1'b1; in_valid = 1'b1; in_op = OP_ADD; in_rob_tag = 4'd6;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_op = OP_NOP;
    sb.delete();
    @(negedge clk);
    chk("clear_valid", 32'(out_valid), 32'h0);
    chk("clear_idle_ready", 32'(in_ready), 32'h1);
    n = 0;
    repeat (50) begin @(negedge clk); if (out_valid) n++; end
    chk("clear_no_output", 32'(n), 32'h0);
    @(posedge clk); #1;

    // Freeze three cycles in the middle of a divide
    issue(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 32'd0, 32'd0, 1'b0, 4'd7, 3);
    repeat (10) @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    chk("frozen_in_ready", 32'(in_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1 rdy = 1'b1;
    drain();

    // Reset in the middle of a multiply
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 4'd9, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    n = 0;
    repeat (50) begin @(negedge clk); if (out_valid) n++; end
    chk("midrst_no_output", 32'(n), 32'h0);
    @(posedge clk); #1;

    // Randomized traffic with random CDB grants
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(1, 22);
      issue(op, rnd_val(), rnd_val(), rnd_val(), $urandom, 1'($urandom_range(0, 1)),
            4'($urandom_range(1, 15)), 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
